uart_rx_param: RTL and testbench

Parametrised UART receiver: the next-generation serial-to-stream deserialiser for the UART core. Supports configurable data width, parity mode and stop-bit count. Oversamples the line at OVERSAMPLE× baud and majority-votes three centre samples per bit. Detects framing, parity and overrun errors, holds the received word on a ready/valid stream and re-arms cleanly after a line break. Sits between the pad-side `i_rxd` and the RX FIFO or consumer; `i_tick` comes from the shared baud prescaler, which `o_rxsync` re-phases.

---
 rtl/uart_rx_param.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param
//  Purpose  : Oversampling UART receiver with 3-sample majority vote, parity,
//             framing and overrun detection, ready/valid output, break re-arm.
//  Revision : 1.0
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  input  logic                 i_tick,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_rxsync,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] c_tick_last = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] c_tick_s0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] c_tick_s1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] c_tick_s2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0]    c_stop_last = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [3:0]             bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             samp_q, samp_d;
  logic                   vote_q, vote_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   commit_q, commit_d;
  logic                   cferr_q, cferr_d;
  logic                   cperr_q, cperr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rxsync_q, rxsync_d;

  logic w_rxd_s;
  logic w_active;
  logic w_bit_end;
  logic w_last_samp;
  logic w_vote_now;
  logic w_par_exp;
  logic w_stop_bad;

  assign w_rxd_s     = sync_q[SYNC_STAGES-1];
  assign w_active    = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);
  assign w_bit_end   = i_tick && (tcnt_q == c_tick_last);
  assign w_last_samp = i_tick && (tcnt_q == c_tick_s2);
  // Third sample is the live line, so the vote is usable on the same tick.
  assign w_vote_now  = (samp_q[0] & samp_q[1]) | (samp_q[0] & w_rxd_s) |
                       (samp_q[1] & w_rxd_s);
  assign w_par_exp   = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
  assign w_stop_bad  = ~w_vote_now;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], i_rxd};
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    samp_d       = samp_q;
    vote_d       = vote_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    commit_d     = 1'b0;
    cferr_d      = cferr_q;
    cperr_d      = cperr_q;
    rxsync_d     = 1'b0;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    if (w_active && i_tick) begin
      tcnt_d = (tcnt_q == c_tick_last) ? '0 : tcnt_q + 1'b1;
      if (tcnt_q == c_tick_s0) samp_d[0] = w_rxd_s;
      if (tcnt_q == c_tick_s1) samp_d[1] = w_rxd_s;
      if (tcnt_q == c_tick_s2) vote_d    = w_vote_now;
    end

    case (state_q)
      S_IDLE: begin
        if (!w_rxd_s) begin
          state_d  = S_START;
          tcnt_d   = '0;
          bcnt_d   = '0;
          shift_d  = '0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
          rxsync_d = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) state_d = vote_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          shift_d = {vote_q, shift_q[DATA_BITS-1:1]};
          if (bcnt_q == c_data_last) begin
            bcnt_d  = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          perr_d  = (vote_q != w_par_exp);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Commit at the last centre sample so the next start edge is not missed.
        if (w_last_samp) begin
          if (bcnt_q == c_stop_last) begin
            commit_d = 1'b1;
            cferr_d  = ferr_q | w_stop_bad;
            cperr_d  = perr_q;
            state_d  = (ferr_q | w_stop_bad) ? S_BRK_WAIT : S_IDLE;
          end else begin
            ferr_d = ferr_q | w_stop_bad;
          end
        end else if (w_bit_end) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_BRK_WAIT: begin
        if (w_rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (valid_q && i_ready) valid_d = 1'b0;
    if (commit_q) begin
      if (cferr_q) begin
        frame_err_d = 1'b1;
      end else if (cperr_q) begin
        parity_err_d = 1'b1;
      end else if (valid_q && !i_ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q       <= '1;
      state_q      <= S_IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      vote_q       <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      commit_q     <= 1'b0;
      cferr_q      <= 1'b0;
      cperr_q      <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      rxsync_q     <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      samp_q       <= samp_d;
      vote_q       <= vote_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      commit_q     <= commit_d;
      cferr_q      <= cferr_d;
      cperr_q      <= cperr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      rxsync_q     <= rxsync_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overrun    = overrun_q;
  assign o_rxsync     = rxsync_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_param
//  Purpose  : Self-checking bench for uart_rx_param (8E1, 16x, tick every 4).
//  Revision : 1.0
// ============================================================================
module tb_uart_rx_param;
  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst, rxd, tick, ready;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_parity_err, o_overrun, o_rxsync, o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ferr = 0, n_perr = 0, n_ovr = 0, n_sync = 0;
  int s_ferr, s_perr, s_ovr, s_sync;
  logic [7:0] got[$];

  uart_rx_param #(
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .SYNC_STAGES(3)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd), .i_tick(tick),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err),
    .o_overrun(o_overrun), .o_rxsync(o_rxsync), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse counting and handshake capture just after the falling edge.
  initial begin
    logic [7:0] prev_data;
    bit         prev_hold;
    prev_data = '0;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (o_frame_err)  n_ferr++;
      if (o_parity_err) n_perr++;
      if (o_overrun)    n_ovr++;
      if (o_rxsync)     n_sync++;
      if (prev_hold && o_valid) check("data_stable", o_data, prev_data);
      if (o_valid && ready && !rst) got.push_back(o_data);
      prev_hold = o_valid && !ready && !rst;
      prev_data = o_data;
    end
  end

  task automatic snap();
    s_ferr = n_ferr; s_perr = n_perr; s_ovr = n_ovr; s_sync = n_sync;
    got.delete();
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // bits[0] = start ... bits[10] = stop; glitch flips one tick-width mid data bit g.
  task automatic send_bits(input logic [10:0] bits, input int g);
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        rxd = bits[b];
        if (b == g + 1 && c >= 34 && c < 38) rxd = ~bits[b];
        @(negedge clk);
      end
    end
    rxd = 1'b1;
    if (!bits[10]) repeat (16) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit pf, input bit sb);
    logic p;
    p = (^d) ^ pf;
    return {~sb, p, d, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] data;
    bit         par_flip;
    bit         stop_bad;
    int         glitch;
    int         exp_words;
    logic [7:0] exp_word;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [10:0] fr;
    logic [7:0]  exp_q[$];
    int          exp_perr, exp_ferr, nf;

    vecs[0] = '{8'hA5, 1'b0, 1'b0,  3, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, -1, 0, 8'h00, 1, 0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, -1, 1, 8'h00, 0, 0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0,  5, 1, 8'hFF, 0, 0};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, -1, 0, 8'h00, 0, 1};
    vecs[5] = '{8'h80, 1'b1, 1'b1, -1, 0, 8'h00, 0, 1};
    vecs[6] = '{8'h7E, 1'b0, 1'b0,  0, 1, 8'h7E, 0, 0};

    rst = 1'b1; rxd = 1'b1; ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", o_data, 0);
    check("rst_valid", o_valid, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_perr", o_parity_err, 0);
    check("rst_ovr", o_overrun, 0);
    check("rst_sync", o_rxsync, 0);
    check("rst_busy", o_busy, 0);
    idle(20);

    for (int i = 0; i < 7; i++) begin
      snap();
      send_bits(mk_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop_bad), vecs[i].glitch);
      idle(20);
      check($sformatf("v%0d_words", i), got.size(), vecs[i].exp_words);
      if (vecs[i].exp_words == 1 && got.size() == 1)
        check($sformatf("v%0d_data", i), got[0], vecs[i].exp_word);
      check($sformatf("v%0d_perr", i), n_perr - s_perr, vecs[i].exp_perr);
      check($sformatf("v%0d_ferr", i), n_ferr - s_ferr, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr", i), n_ovr - s_ovr, 0);
      check($sformatf("v%0d_sync", i), n_sync - s_sync, 1);
    end

    // Overrun: consumer stalled across two frames.
    snap();
    ready = 1'b0;
    send_bits(mk_frame(8'h3C, 1'b0, 1'b0), -1);
    send_bits(mk_frame(8'h81, 1'b0, 1'b0), -1);
    idle(20);
    check("ovr_valid", o_valid, 1);
    check("ovr_data", o_data, 8'h3C);
    check("ovr_pulse", n_ovr - s_ovr, 1);
    check("ovr_words", got.size(), 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("ovr_drain_valid", o_valid, 0);
    check("ovr_drain_words", got.size(), 1);
    if (got.size() == 1) check("ovr_drain_data", got[0], 8'h3C);
    ready = 1'b1;
    idle(20);

    // False start: short low pulse.
    snap();
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    idle(30);
    check("fs_busy_mid", o_busy, 1);
    idle(40);
    check("fs_busy_end", o_busy, 0);
    check("fs_sync", n_sync - s_sync, 1);
    check("fs_words", got.size(), 0);
    check("fs_errs", (n_ferr - s_ferr) + (n_perr - s_perr), 0);

    // Line break for 30 bit times, then a normal frame.
    snap();
    rxd = 1'b0;
    for (int k = 0; k < 30; k++) begin
      repeat (BIT_CLKS) @(negedge clk);
      if (k % 5 == 4) check($sformatf("brk_busy_%0d", k), o_busy, 1);
    end
    check("brk_ferr", n_ferr - s_ferr, 1);
    check("brk_sync", n_sync - s_sync, 1);
    idle(10);
    check("brk_busy_release", o_busy, 0);
    send_bits(mk_frame(8'h55, 1'b0, 1'b0), -1);
    idle(20);
    check("brk_words", got.size(), 1);
    if (got.size() == 1) check("brk_data", got[0], 8'h55);
    check("brk_ferr_total", n_ferr - s_ferr, 1);
    check("brk_perr", n_perr - s_perr, 0);

    // Reset during data bit 4 of 0xFF, line then idles.
    snap();
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * BIT_CLKS + 32) @(negedge clk);
    check("mrst_busy_before", o_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_data", o_data, 0);
    check("mrst_valid", o_valid, 0);
    check("mrst_busy", o_busy, 0);
    idle(150);
    check("mrst_flags", (n_ferr - s_ferr) + (n_perr - s_perr) + (n_ovr - s_ovr), 0);
    check("mrst_words", got.size(), 0);
    send_bits(mk_frame(8'h0F, 1'b0, 1'b0), -1);
    idle(20);
    check("mrst_next_words", got.size(), 1);
    if (got.size() == 1) check("mrst_next_data", got[0], 8'h0F);

    // Random frames scored against a frame-level model of the line protocol.
    snap();
    exp_q.delete();
    exp_perr = 0;
    exp_ferr = 0;
    nf = 24;
    for (int n = 0; n < nf; n++) begin
      logic [7:0] d;
      int         g;
      d  = 8'($urandom_range(0, 255));
      fr = mk_frame(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      if (fr[10] == 1'b0)       exp_ferr++;
      else if (^fr[9:1] != 1'b0) exp_perr++;
      else                       exp_q.push_back(fr[8:1]);
      send_bits(fr, g);
      idle($urandom_range(0, 40));
    end
    idle(20);
    check("rnd_words", got.size(), exp_q.size());
    if (got.size() == exp_q.size())
      for (int j = 0; j < exp_q.size(); j++) check($sformatf("rnd_data_%0d", j), got[j], exp_q[j]);
    check("rnd_perr", n_perr - s_perr, exp_perr);
    check("rnd_ferr", n_ferr - s_ferr, exp_ferr);
    check("rnd_ovr", n_ovr - s_ovr, 0);
    check("rnd_sync", n_sync - s_sync, nf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
